cordic_sin_seq: RTL and testbench
=================================

# cordic_sin_seq

Iteration sequencer for the CORDIC sin/cos engine. It computes sin θ and cos θ in rotation mode using one shared floating-point multiplier port and one shared floating-point adder port, time-multiplexed three operations per iteration. It keeps the shift factor 2^-i as a running product that is multiplied by 0.5 each iteration. The block sits between the top-level angle request interface and the combinational IEEE-754 single-precision multiplier and adder.

## Interface
- N, 16: number of CORDIC iterations (1..32).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- theta  in  32  angle, IEEE-754 single, radians, |θ| ≤ π/2.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when results are valid.
- sin_out  out  32  result y, registered, held until the next accepted start.
- cos_out  out  32  result x, registered, held until the next accepted start.
- mul_a, mul_b  out  32  operands to the shared multiplier.
- mul_p  in  32  product, combinational, same cycle.
- add_a, add_b  out  32  operands to the shared adder.
- add_s  in  32  sum, combinational, same cycle.

## Operation
- Registers:
  - x, y, z: working values.
  - scale: 2^-i.
  - xs, ys: scaled products.
  - d: direction, 1 = subtract.
  - i: iteration counter, 0..N-1.
  - st: state.
- IDLE, start=1 loads:
  - x = K = 0x3F1B74EE (0.607253).
  - y = 0.
  - z = theta.
  - scale = 0x3F800000.
  - i = 0.
  - Next state S0.
- S0:
  - d ← z[31].
  - mul: x·scale → xs.
  - add: z + (d ? +atan_i : −atan_i) → z. For d=0 the atan sign bit is flipped.
- S1:
  - mul: y·scale → ys. This uses the old y; y updates at the same edge.
  - add: y + (d ? −xs : +xs) → y.
- S2:
  - mul: scale·0x3F000000 → scale.
  - add: x + (d ? +ys : −ys) → x.
  - If i = N-1, next state is DONE; otherwise i++ and next state is S0.
- DONE:
  - sin_out ← y and cos_out ← x, captured at entry.
  - done = 1 for exactly this cycle.
  - Next state IDLE.
- Negation is a sign-bit flip of the operand only; there is no arithmetic negate.
- atan_i comes from sub-module cordic_atan_rom, indexed by i.
- d is taken from the sign bit of z at the start of the iteration: z[31]=1 (negative) means rotate negative.
- start while st ≠ IDLE is ignored. The DONE cycle counts as busy.
- Inputs are assumed normal or zero; no NaN/Inf handling. The atan ROM table is fixed to 32 entries.

## Timing
- Start accepted at edge 0:
  - S0 of iteration 0 occupies cycle 1.
  - Iteration i occupies cycles 3i+1..3i+3.
  - DONE occupies cycle 3N+1 (cycle 49 for N=16).
- Results appear on sin_out/cos_out in cycle 3N+1, coincident with done.
- The earliest next start is sampled in cycle 3N+2 (IDLE).
- mul_a/mul_b/add_a/add_b are driven combinationally from st. They are driven to 0 in IDLE and DONE.
- Reset values:
  - st = IDLE, busy = 0, done = 0.
  - sin_out = cos_out = 0.
  - All working registers 0; scale = 0x3F800000.
- Reset mid-operation aborts immediately. There is no done pulse, and outputs return to 0.
- reset and start in the same cycle: reset wins.

## Structure
- Shared package cordic_pkg holds:
  - State enum: IDLE, S0, S1, S2, DONE.
  - Constants: K_INIT, FP_ONE, FP_HALF, FP_ZERO.
  - ATAN_TABLE[0..31], atan(2^-i) in single precision.
- Sub-module cordic_atan_rom: combinational index → atan value lookup over ATAN_TABLE.
- The multiplier and adder stay outside this block. The bench instantiates the existing floating-point multiplier and a floating-point adder against the ports.

## Test plan
- θ = 0x00000000, N=16 → done at cycle 49; cos_out ≈ 0x3F800000 and sin_out ≈ 0, each within 2^-14 absolute.
- θ = π/6 (0x3F060A92) → sin_out ≈ 0x3F000000 (0.5) and cos_out ≈ 0.866025, each within 2^-14.
- θ = −π/4 (0xBF490FDB) → sin_out ≈ −0.707107 and cos_out ≈ +0.707107. Check that d=1 in iteration 0.
- Iteration 0 port trace for θ = π/6:
  - Cycle 1: mul = (K, 1.0), add_b = −atan(1).
  - Cycle 3: mul = (1.0, 0.5).
  - Final scale = 2^-16 (0x37800000).
- Second start pulsed in cycle 10 → ignored; single done at cycle 49; results match a single run.
- Reset asserted in cycle 20 → busy = 0, no done pulse, outputs = 0. A fresh start afterwards completes normally at 3N+1 cycles.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sin/cos iteration sequencer.
// The arctangent table holds atan(2^-i) in IEEE-754 single precision.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [31:0] K_INIT  = 32'h3F1B74EE;
    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_HALF = 32'h3F000000;
    localparam logic [31:0] FP_ZERO = 32'h00000000;

    // From i = 12 onward atan(2^-i) rounds to 2^-i exactly in single precision.
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5,
        32'h3D7FAADE, 32'h3CFFEAAE, 32'h3C7FFAAB, 32'h3BFFFEAB,
        32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
        32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000,
        32'h37800000, 32'h37000000, 32'h36800000, 32'h36000000,
        32'h35800000, 32'h35000000, 32'h34800000, 32'h34000000,
        32'h33800000, 32'h33000000, 32'h32800000, 32'h32000000,
        32'h31800000, 32'h31000000, 32'h30800000, 32'h30000000
    };

    function automatic logic [31:0] fp_neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

endpackage

// File: rtl/cordic_sin_seq_atan_rom.sv
// Combinational lookup of atan(2^-idx) from the shared table.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [4:0]  idx,
    output logic [31:0] atan
);

    assign atan = ATAN_TABLE[idx];

endmodule

// File: rtl/cordic_sin_seq.sv
// CORDIC rotation-mode sequencer: three shared mul/add operations per iteration,
// with the 2^-i shift kept as a running product halved every iteration.
//
// state | meaning
// IDLE  | waiting for start, shared ports driven to zero
// S0    | xs = x*scale, z += -/+atan_i, latch direction from z sign
// S1    | ys = y*scale, y += -/+xs
// S2    | scale *= 0.5, x += +/-ys, advance or finish
// DONE  | results valid, one-cycle done pulse
module cordic_sin_seq
    import cordic_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] theta,
    output logic        busy,
    output logic        done,
    output logic [31:0] sin_out,
    output logic [31:0] cos_out,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_s
);

    localparam logic [4:0] I_LAST = 5'(N - 1);

    state_t      st, st_nxt;
    logic [31:0] x, y, z, scale, xs, ys;
    logic        d;
    logic [4:0]  i;
    logic [31:0] atan;

    cordic_atan_rom u_atan_rom (
        .idx  (i),
        .atan (atan)
    );

    assign busy = (st != IDLE);
    assign done = (st == DONE);

    always_comb begin
        st_nxt = st;
        mul_a  = FP_ZERO;
        mul_b  = FP_ZERO;
        add_a  = FP_ZERO;
        add_b  = FP_ZERO;
        case (st)
            IDLE: begin
                if (start) st_nxt = S0;
            end
            S0: begin
                // Direction is not registered yet here, so use z's sign directly.
                mul_a  = x;
                mul_b  = scale;
                add_a  = z;
                add_b  = z[31] ? atan : fp_neg(atan);
                st_nxt = S1;
            end
            S1: begin
                mul_a  = y;
                mul_b  = scale;
                add_a  = y;
                add_b  = d ? fp_neg(xs) : xs;
                st_nxt = S2;
            end
            S2: begin
                mul_a  = scale;
                mul_b  = FP_HALF;
                add_a  = x;
                add_b  = d ? ys : fp_neg(ys);
                st_nxt = (i == I_LAST) ? DONE : S0;
            end
            DONE: begin
                st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            x       <= FP_ZERO;
            y       <= FP_ZERO;
            z       <= FP_ZERO;
            xs      <= FP_ZERO;
            ys      <= FP_ZERO;
            d       <= 1'b0;
            scale   <= FP_ONE;
            i       <= '0;
            sin_out <= FP_ZERO;
            cos_out <= FP_ZERO;
        end else begin
            st <= st_nxt;
            case (st)
                IDLE: begin
                    if (start) begin
                        x     <= K_INIT;
                        y     <= FP_ZERO;
                        z     <= theta;
                        scale <= FP_ONE;
                        i     <= '0;
                    end
                end
                S0: begin
                    d  <= z[31];
                    xs <= mul_p;
                    z  <= add_s;
                end
                S1: begin
                    ys <= mul_p;
                    y  <= add_s;
                end
                S2: begin
                    scale <= mul_p;
                    x     <= add_s;
                    // x's final value is on add_s this cycle; y settled in S1.
                    if (i == I_LAST) begin
                        cos_out <= add_s;
                        sin_out <= y;
                    end else begin
                        i <= i + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sin_seq.sv
// Bench for cordic_sin_seq: behavioural FP mul/add on the shared ports, an
// algorithm-level model of the port trace and results, and directed runs.
module tb_cordic_sin_seq;

    localparam int N     = 16;
    localparam int T_END = 3 * N + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] theta = 32'h0;
    logic        busy, done;
    logic [31:0] sin_out, cos_out;
    logic [31:0] mul_a, mul_b, mul_p, add_a, add_b, add_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Single-precision helpers through double; products of two singles are exact in double.
    function automatic real s2r(input logic [31:0] b);
        logic [63:0] db;
        if (b[30:0] == 31'd0) return $bitstoreal({b[31], 63'd0});
        db = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(db);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] db;
        int          e;
        logic        up;
        logic [30:0] v;
        db = $realtobits(r);
        e  = int'(db[62:52]) - 1023 + 127;
        if (e < 1) return {db[63], 31'd0};
        up = db[28] && ((db[27:0] != 28'd0) || db[29]);
        v  = {8'(e), db[51:29]} + 31'(up);
        return {db[63], v};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) * s2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] neg(input logic [31:0] v);
        return {~v[31], v[30:0]};
    endfunction

    assign mul_p = fmul(mul_a, mul_b);
    assign add_s = fadd(add_a, add_b);

    cordic_sin_seq #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .theta   (theta),
        .busy    (busy),
        .done    (done),
        .sin_out (sin_out),
        .cos_out (cos_out),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_s   (add_s)
    );

    // Model: expected per-cycle port trace and final results of one rotation.
    logic [31:0] tr_ma [3*N];
    logic [31:0] tr_mb [3*N];
    logic [31:0] tr_aa [3*N];
    logic [31:0] tr_ab [3*N];
    logic [31:0] m_x, m_y, m_sc;
    int          m_cyc = 0;
    logic [31:0] m_sin = 32'h0;
    logic [31:0] m_cos = 32'h0;

    function automatic void compute(input logic [31:0] th);
        logic [31:0] x, y, z, sc, xs, ys, at;
        logic        dd;
        x = 32'h3F1B74EE; y = 32'h0; z = th; sc = 32'h3F800000;
        for (int it = 0; it < N; it++) begin
            at = r2s($atan(1.0 / (2.0 ** it)));
            dd = z[31];
            tr_ma[3*it] = x;  tr_mb[3*it] = sc;  tr_aa[3*it] = z;
            tr_ab[3*it] = dd ? at : neg(at);
            xs = fmul(x, sc);
            z  = fadd(z, tr_ab[3*it]);
            tr_ma[3*it+1] = y;  tr_mb[3*it+1] = sc;  tr_aa[3*it+1] = y;
            tr_ab[3*it+1] = dd ? neg(xs) : xs;
            ys = fmul(y, sc);
            y  = fadd(y, tr_ab[3*it+1]);
            tr_ma[3*it+2] = sc;  tr_mb[3*it+2] = 32'h3F000000;  tr_aa[3*it+2] = x;
            tr_ab[3*it+2] = dd ? ys : neg(ys);
            sc = fmul(sc, 32'h3F000000);
            x  = fadd(x, tr_ab[3*it+2]);
        end
        m_x = x; m_y = y; m_sc = sc;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc <= 0;
            m_sin <= 32'h0;
            m_cos <= 32'h0;
        end else if (m_cyc == 0) begin
            if (start) begin
                compute(theta);
                m_cyc <= 1;
            end
        end else if (m_cyc == T_END) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc == T_END - 1) begin
                m_sin <= m_y;
                m_cos <= m_x;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input logic [31:0] act, input real req);
        real diff;
        checks++;
        diff = s2r(act) - req;
        if (diff < 0.0) diff = -diff;
        if (diff > 1.0 / 16384.0) begin
            failures++;
            $display("FAIL %s actual=%h (%f) required=%f +/- 2^-14", name, act, s2r(act), req);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        logic [31:0] e_ma, e_mb, e_aa, e_ab;
        #1;
        if (chk_en) begin
            e_ma = 32'h0; e_mb = 32'h0; e_aa = 32'h0; e_ab = 32'h0;
            if (m_cyc >= 1 && m_cyc <= 3 * N) begin
                e_ma = tr_ma[m_cyc-1]; e_mb = tr_mb[m_cyc-1];
                e_aa = tr_aa[m_cyc-1]; e_ab = tr_ab[m_cyc-1];
            end
            chk("busy", 32'(busy), 32'(m_cyc != 0));
            chk("done", 32'(done), 32'(m_cyc == T_END));
            chk("mul_a", mul_a, e_ma);
            chk("mul_b", mul_b, e_mb);
            chk("add_a", add_a, e_aa);
            chk("add_b", add_b, e_ab);
            chk("sin_out", sin_out, m_sin);
            chk("cos_out", cos_out, m_cos);
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_run(input logic [31:0] th);
        @(negedge clk);
        theta = th;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(output int at, output int extra);
        at = -1;
        extra = 0;
        while (cyc < 200) begin
            if (done) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_by_cycle_%0d", T_END);
        end
        repeat (12) begin
            step();
            if (done) extra++;
        end
    endtask

    localparam real PI = 3.14159265358979;

    initial begin
        int dc, nd;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sin", sin_out, 32'h0);
        chk("rst_cos", cos_out, 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        start_run(32'h00000000);
        wait_done(dc, nd);
        chk("zero_done_cycle", dc, T_END);
        chk("zero_extra_done", nd, 0);
        chk_tol("zero_cos", cos_out, 1.0);
        chk_tol("zero_sin", sin_out, 0.0);

        start_run(32'h3F060A92);
        chk("pi6_c1_mul_a", mul_a, 32'h3F1B74EE);
        chk("pi6_c1_mul_b", mul_b, 32'h3F800000);
        chk("pi6_c1_add_b", add_b, 32'hBF490FDB);
        step();
        step();
        chk("pi6_c3_mul_a", mul_a, 32'h3F800000);
        chk("pi6_c3_mul_b", mul_b, 32'h3F000000);
        chk("model_final_scale", m_sc, 32'h37800000);
        wait_done(dc, nd);
        chk("pi6_done_cycle", dc, T_END);
        chk_tol("pi6_sin", sin_out, 0.5);
        chk_tol("pi6_cos", cos_out, 0.8660254);

        start_run(32'h3F060A92);
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(dc, nd);
        chk("restart_done_cycle", dc, T_END);
        chk("restart_extra_done", nd, 0);
        chk_tol("restart_sin", sin_out, 0.5);

        start_run(32'hBF490FDB);
        chk("neg_d1_add_b", add_b, 32'h3F490FDB);
        wait_done(dc, nd);
        chk("neg_done_cycle", dc, T_END);
        chk_tol("neg_sin", sin_out, -0.70710678);
        chk_tol("neg_cos", cos_out, 0.70710678);

        start_run(32'h3F060A92);
        repeat (19) step();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sin", sin_out, 32'h0);
        chk("abort_cos", cos_out, 32'h0);
        step();
        reset = 1'b0;
        nd = 0;
        repeat (60) begin
            step();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);

        start_run(32'h3F800000);
        wait_done(dc, nd);
        chk("fresh_done_cycle", dc, T_END);
        chk_tol("fresh_sin", sin_out, $sin(1.0));
        chk_tol("fresh_cos", cos_out, $cos(1.0));

        chk_tol("model_pi4_ref", 32'h3F3504F3, $cos(PI / 4.0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
